// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32 5-stage pipeline.
//   XLEN / REG_ADDR_W : datapath and register-address widths
//   ALU_OP_W          : ALU-op field width carried by the ID/EX register
//   mem_state_e       : MEM-stage access FSM states
//   mem_ctrl_t        : control-bit bundle carried from ID/EX into EX/MEM
package rv_pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 4;
  localparam int MEM_CTRL_W = 5;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic valid;
    logic regWrite;
    logic memToReg;
    logic memRead;
    logic memWrite;
  } mem_ctrl_t;

endpackage

// File: rtl/data_mem_rv.sv
// Word-addressed data memory: 2**ADDR_WIDTH x XLEN, asynchronous read,
// synchronous write on the rising clock edge. Contents are never reset.
//   clock   : write clock
//   i_we    : write enable
//   i_addr  : word index (shared by read and write)
//   i_wdata : write data
//   o_rdata : combinational read data at i_addr
module data_mem_rv
  import rv_pipe_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [XLEN-1:0]       i_wdata,
  output logic [XLEN-1:0]       o_rdata
);

  logic [XLEN-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage_rv.sv
// MEM stage of the RV32 pipeline: EX/MEM register, data memory with a
// configurable access latency, MEM/WB register and the forwarding tags.
//   clock, reset           : pipeline clock, async active-high reset
//   ex_*                   : instruction arriving from the EX stage
//   exmem_*                : EX/MEM register contents (forwarding source)
//   memwb_*                : MEM/WB register contents (register-file write)
//   mem_stall              : combinational; freezes PC, IF/ID and ID/EX
//   misaligned_fault       : one-cycle pulse aligned with MEM/WB
module mem_stage_rv
  import rv_pipe_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic                  ex_regWrite,
  input  logic                  ex_memToReg,
  input  logic                  ex_memRead,
  input  logic                  ex_memWrite,
  input  logic [XLEN-1:0]       ex_aluResult,
  input  logic [XLEN-1:0]       ex_storeData,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  exmem_valid,
  output logic                  exmem_regWrite,
  output logic [REG_ADDR_W-1:0] exmem_rd,
  output logic [XLEN-1:0]       exmem_aluResult,
  output logic                  memwb_valid,
  output logic                  memwb_regWrite,
  output logic [REG_ADDR_W-1:0] memwb_rd,
  output logic [XLEN-1:0]       memwb_writeData,
  output logic                  mem_stall,
  output logic                  misaligned_fault
);

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  mem_state_e            r_state;
  logic [2:0]            r_wait_cnt;
  mem_ctrl_t             r_exmem_ctrl;
  logic [XLEN-1:0]       r_exmem_alu;
  logic [XLEN-1:0]       r_exmem_sd;
  logic [REG_ADDR_W-1:0] r_exmem_rd;
  logic                  r_memwb_valid;
  logic                  r_memwb_regWrite;
  logic [REG_ADDR_W-1:0] r_memwb_rd;
  logic [XLEN-1:0]       r_memwb_data;
  logic                  r_fault;

  logic                  w_aligned;
  logic                  w_memop;
  logic                  w_access;
  logic                  w_misaligned;
  logic                  w_stall;
  logic                  w_we;
  logic [XLEN-1:0]       w_rdata;

  assign w_aligned    = (r_exmem_alu[1:0] == 2'b00);
  assign w_memop      = r_exmem_ctrl.valid & (r_exmem_ctrl.memRead | r_exmem_ctrl.memWrite);
  assign w_access     = w_memop & w_aligned;
  assign w_misaligned = w_memop & ~w_aligned;

  // An access stalls in every cycle but its last; the last (completion)
  // cycle is the only one with the stall low, so the write fires exactly once.
  always_comb begin
    w_stall = 1'b0;
    if (LAT != 3'd0) begin
      case (r_state)
        MEM_IDLE: w_stall = w_access;
        MEM_WAIT: w_stall = (r_wait_cnt < LAT);
        default:  w_stall = 1'b0;
      endcase
    end
  end

  assign w_we = w_access & r_exmem_ctrl.memWrite & ~w_stall;

  data_mem_rv #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dmem (
    .clock   (clock),
    .i_we    (w_we),
    .i_addr  (r_exmem_alu[ADDR_WIDTH+1:2]),
    .i_wdata (r_exmem_sd),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= MEM_IDLE;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        MEM_IDLE: begin
          if (w_access && (LAT != 3'd0)) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= 3'd1;
          end
        end
        MEM_WAIT: begin
          if (r_wait_cnt < LAT) begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
          end else begin
            r_state    <= MEM_IDLE;
            r_wait_cnt <= '0;
          end
        end
        default: begin
          r_state    <= MEM_IDLE;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_exmem_ctrl     <= '0;
      r_exmem_alu      <= '0;
      r_exmem_sd       <= '0;
      r_exmem_rd       <= '0;
      r_memwb_valid    <= 1'b0;
      r_memwb_regWrite <= 1'b0;
      r_memwb_rd       <= '0;
      r_memwb_data     <= '0;
      r_fault          <= 1'b0;
    end else if (w_stall) begin
      // EX/MEM holds; MEM/WB takes a bubble but keeps rd/data.
      r_memwb_valid    <= 1'b0;
      r_memwb_regWrite <= 1'b0;
      r_fault          <= 1'b0;
    end else begin
      r_exmem_ctrl     <= '{valid:    ex_valid,
                            regWrite: ex_regWrite,
                            memToReg: ex_memToReg,
                            memRead:  ex_memRead,
                            memWrite: ex_memWrite};
      r_exmem_alu      <= ex_aluResult;
      r_exmem_sd       <= ex_storeData;
      r_exmem_rd       <= ex_rd;
      r_memwb_valid    <= r_exmem_ctrl.valid;
      r_memwb_regWrite <= r_exmem_ctrl.valid & r_exmem_ctrl.regWrite &
                          (r_exmem_rd != '0) & ~w_misaligned;
      r_memwb_rd       <= r_exmem_rd;
      r_memwb_data     <= r_exmem_ctrl.memToReg ? w_rdata : r_exmem_alu;
      r_fault          <= w_misaligned;
    end
  end

  assign exmem_valid      = r_exmem_ctrl.valid;
  assign exmem_regWrite   = r_exmem_ctrl.regWrite;
  assign exmem_rd         = r_exmem_rd;
  assign exmem_aluResult  = r_exmem_alu;
  assign memwb_valid      = r_memwb_valid;
  assign memwb_regWrite   = r_memwb_regWrite;
  assign memwb_rd         = r_memwb_rd;
  assign memwb_writeData  = r_memwb_data;
  assign mem_stall        = w_stall;
  assign misaligned_fault = r_fault;

endmodule
